ps2_scan_ctrl: RTL and testbench
================================

# ps2_scan_ctrl

PS/2 scan-code controller sitting between the PS/2 byte receiver and the keyboard-consuming logic (display/LED/alarm control). It enables the receiver, folds the set-2 prefix bytes (E0 extended, F0 break) into single key events, buffers the events in a small FIFO with a valid/ready handshake, and aborts the receiver through a watchdog when a frame stalls.

## Interface
- TIMEOUT_CYC, 200000, clk cycles a frame may stay in progress before abort (2 ms at 100 MHz)
- FIFO_DEPTH, 4, event FIFO entries (power of two, ≥2)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- rx_done_tick  in  1  one-cycle pulse from receiver: rx_data holds a complete byte
- rx_data  in  8  received byte, valid only with rx_done_tick
- rx_busy  in  1  receiver is mid-frame (start bit seen, stop bit not yet)
- rx_en  out  1  receiver enable
- rx_abort  out  1  one-cycle pulse: receiver must drop its partial frame
- key_valid  out  1  FIFO head holds an event
- key_ready  in  1  consumer accepts head this cycle
- key_code  out  8  head event scan code
- key_ext  out  1  head event had E0 prefix
- key_brk  out  1  head event is a release (F0 prefix)
- err  out  2  sticky: [0] FIFO overflow, [1] watchdog timeout
- clr_err  in  1  clears err (pulse)

## Operation
- Decoder FSM states: IDLE, PFX_E0, PFX_F0, PFX_E0F0. Transitions on rx_done_tick only:
  - IDLE: E0→PFX_E0; F0→PFX_F0; other→emit {ext=0,brk=0}, stay
  - PFX_E0: F0→PFX_E0F0; E0→stay; other→emit {1,0}, IDLE
  - PFX_F0: other→emit {0,1}, IDLE; F0/E0→IDLE, no emit (malformed)
  - PFX_E0F0: other→emit {1,1}, IDLE; F0/E0→IDLE, no emit
- Bytes 00 and FF (keyboard error/overrun) in any state: no emit, FSM→IDLE.
- Emit = FIFO push of {ext, brk, code} (10 bits). Push while full and no pop in same cycle: event dropped, err[0] set.
- Pop when key_valid & key_ready. Simultaneous push and pop while full: both succeed, no overflow.
- rx_en: 0 during reset, 1 otherwise except the cycle rx_abort is high.
- Watchdog: counter increments each cycle rx_busy=1; clears when rx_busy=0 or rx_done_tick=1. On reaching TIMEOUT_CYC-1: rx_abort pulses one cycle, counter clears, FSM→IDLE (pending prefix discarded), err[1] set.
- rx_done_tick has priority over watchdog expiry in the same cycle: byte processed, no abort.
- clr_err in same cycle as a new error: error wins (bit stays set).

## Timing
- Reset values: rx_en=0, rx_abort=0, key_valid=0, key_code=00, key_ext=0, key_brk=0, err=00, FSM=IDLE, FIFO empty, watchdog=0.
- Byte latency: rx_done_tick sampled at edge k; event written at edge k; key_valid=1 and head fields valid after edge k when FIFO was empty (1-cycle latency).
- Pop at edge k; next entry visible after edge k; key_valid falls after edge k if last entry.
- FIFO outputs are show-ahead and registered; fields stable while key_valid=1 and key_ready=0.
- rx_abort asserted exactly one cycle per expiry; next expiry needs a further TIMEOUT_CYC busy cycles.
- Reset assertion mid-frame or mid-prefix: all state cleared immediately, FIFO contents lost.

## Structure
- Shared package ps2_pkg: byte constants PS2_EXT=E0, PS2_BRK=F0, PS2_ERR0=00, PS2_ERR1=FF; decoder state enum; key-event struct (ext, brk, code[7:0]) and its width.
- One sub-module: ps2_evt_fifo (synchronous FIFO, show-ahead, count-based full/empty, parameter FIFO_DEPTH). FSM and watchdog live in ps2_scan_ctrl.

## Test plan
- Bytes 1C, F0 1C -> events {0,0,1C} then {0,1,1C}; key_valid 1 cycle after first tick.
- Bytes E0 75, E0 F0 75 -> {1,0,75}, {1,1,75}; E0 E0 74 -> single {1,0,74}.
- key_ready=0, send 5 make codes 15,16,1D,1E,24 -> first four held in order, err=01; then push with simultaneous pop while full -> no further err change, order preserved.
- rx_busy held 1 for TIMEOUT_CYC cycles after F0 -> one rx_abort pulse, rx_en low that cycle, err=10; next byte 1C emits {0,0,1C} (prefix discarded).
- rx_done_tick coincident with watchdog expiry -> no rx_abort, byte decoded; byte FF mid-prefix -> no emit, FSM IDLE.
- Assert reset with 3 events queued and F0 pending -> key_valid=0, err=00, rx_en=0 during reset; after release 1C emits {0,0,1C}.

Source files
------------

// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 scan-code controller:
//   - set-2 special byte values (extended prefix, break prefix, error bytes)
//   - decoder state encoding
//   - key-event record pushed through the event FIFO, plus its width
//   - small byte-classification helpers used by the decoder
// ----------------------------------------------------------------------------
package ps2_pkg;

    // Set-2 prefix and keyboard error bytes
    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_ERR0 = 8'h00;
    localparam logic [7:0] PS2_ERR1 = 8'hFF;

    // Decoder state: which prefix bytes have been seen for the pending key
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PFX_E0   = 2'd1,
        ST_PFX_F0   = 2'd2,
        ST_PFX_E0F0 = 2'd3
    } dec_state_t;

    // One folded key event as stored in the FIFO
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_evt_t;

    localparam int KEY_EVT_W = $bits(key_evt_t);

    // Keyboard error / overrun bytes carry no key information
    function automatic logic is_err_byte(input logic [7:0] b);
        return (b == PS2_ERR0) || (b == PS2_ERR1);
    endfunction

    // Either prefix byte
    function automatic logic is_prefix_byte(input logic [7:0] b);
        return (b == PS2_EXT) || (b == PS2_BRK);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ----------------------------------------------------------------------------
// ps2_evt_fifo
// Synchronous show-ahead FIFO for decoded key events. Full/empty are derived
// from an occupancy counter. The head entry is held in its own register so the
// outputs come straight from flops and stay stable while the consumer stalls.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_rst_n     asynchronous active-low reset (contents discarded)
//   i_push      write request for i_wdata
//   i_wdata     entry to write
//   i_pop       consumer accepts the head entry this cycle
//   o_rdata     head entry (valid while o_valid)
//   o_valid     FIFO holds at least one entry
//   o_overflow  push rejected this cycle (full and no pop)
// ----------------------------------------------------------------------------
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = KEY_EVT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_valid,
    output logic             o_overflow
);

    localparam int             PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_full;
    logic             w_popOk;
    logic             w_pushOk;
    logic [PTR_W-1:0] w_rdNext;
    logic [WIDTH-1:0] w_headNext;

    assign w_full   = (r_count == FULL_CNT);
    assign w_popOk  = i_pop && (r_count != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_pushOk = i_push && (!w_full || w_popOk);

    assign o_overflow = i_push && w_full && !w_popOk;
    assign o_valid    = (r_count != '0);
    assign o_rdata    = r_head;

    // Head after this edge: the incoming word when it lands at the new read
    // pointer (empty FIFO, or single entry being popped), else stored data.
    always_comb begin
        w_rdNext   = w_popOk ? (r_rdPtr + 1'b1) : r_rdPtr;
        w_headNext = r_mem[w_rdNext];
        if (w_pushOk && (r_wrPtr == w_rdNext)) begin
            w_headNext = i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_head  <= '0;
        end else begin
            if (w_pushOk) begin
                r_mem[r_wrPtr] <= i_wdata;
                r_wrPtr        <= r_wrPtr + 1'b1;
            end
            r_rdPtr <= w_rdNext;
            r_head  <= w_headNext;
            case ({w_pushOk, w_popOk})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scan_ctrl.sv
// ----------------------------------------------------------------------------
// ps2_scan_ctrl
// Sits between a PS/2 byte receiver and key-consuming logic. Folds set-2
// E0/F0 prefixes into single key events, queues them in a small FIFO with a
// valid/ready handshake, and aborts the receiver if a frame stalls.
//
// Ports:
//   i_clk           system clock, rising edge
//   i_rst_n         asynchronous active-low reset
//   i_rx_done_tick  receiver pulse: i_rx_data holds a complete byte
//   i_rx_data       received byte
//   i_rx_busy       receiver is mid-frame
//   o_rx_en         receiver enable (low in reset and during an abort cycle)
//   o_rx_abort      one-cycle pulse: receiver drops its partial frame
//   o_key_valid     FIFO head holds an event
//   i_key_ready     consumer accepts head this cycle
//   o_key_code      head scan code
//   o_key_ext       head event had E0 prefix
//   o_key_brk       head event is a release
//   o_err           sticky errors: [0] FIFO overflow, [1] watchdog timeout
//   i_clr_err       clears o_err (a same-cycle new error still sets its bit)
// ----------------------------------------------------------------------------
module ps2_scan_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 200000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_done_tick,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_busy,
    output logic       o_rx_en,
    output logic       o_rx_abort,
    output logic       o_key_valid,
    input  logic       i_key_ready,
    output logic [7:0] o_key_code,
    output logic       o_key_ext,
    output logic       o_key_brk,
    output logic [1:0] o_err,
    input  logic       i_clr_err
);

    localparam int              WD_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    dec_state_t      r_state;
    dec_state_t      w_stateNext;
    logic [WD_W-1:0] r_wdCnt;
    logic            r_abort;
    logic            r_enable;
    logic [1:0]      r_err;

    logic            w_expire;
    logic            w_emit;
    key_evt_t        w_evt;
    key_evt_t        w_headEvt;
    logic            w_keyValid;
    logic            w_pop;
    logic            w_overflow;

    // A completed byte in the expiry cycle wins: the frame did finish.
    assign w_expire = i_rx_busy && !i_rx_done_tick && (r_wdCnt == WD_LAST);

    // Watchdog counts consecutive busy cycles of one frame; abort is
    // registered so the receiver sees a clean single-cycle pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wdCnt  <= '0;
            r_abort  <= 1'b0;
            r_enable <= 1'b0;
        end else begin
            r_enable <= 1'b1;
            r_abort  <= w_expire;
            if (!i_rx_busy || i_rx_done_tick || w_expire) begin
                r_wdCnt <= '0;
            end else begin
                r_wdCnt <= r_wdCnt + 1'b1;
            end
        end
    end

    assign o_rx_en    = r_enable && !r_abort;
    assign o_rx_abort = r_abort;

    // Decoder state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Prefix folding: remember E0/F0 until the key byte arrives, then emit
    // one event. Error bytes and stray prefixes after F0 reset the sequence.
    always_comb begin
        w_stateNext = r_state;
        w_emit      = 1'b0;
        w_evt.ext   = 1'b0;
        w_evt.brk   = 1'b0;
        w_evt.code  = i_rx_data;
        if (i_rx_done_tick) begin
            if (is_err_byte(i_rx_data)) begin
                w_stateNext = ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_rx_data == PS2_EXT) begin
                            w_stateNext = ST_PFX_E0;
                        end else if (i_rx_data == PS2_BRK) begin
                            w_stateNext = ST_PFX_F0;
                        end else begin
                            w_emit = 1'b1;
                        end
                    end
                    ST_PFX_E0: begin
                        if (i_rx_data == PS2_BRK) begin
                            w_stateNext = ST_PFX_E0F0;
                        end else if (i_rx_data == PS2_EXT) begin
                            w_stateNext = ST_PFX_E0;
                        end else begin
                            w_emit      = 1'b1;
                            w_evt.ext   = 1'b1;
                            w_stateNext = ST_IDLE;
                        end
                    end
                    ST_PFX_F0: begin
                        w_stateNext = ST_IDLE;
                        if (!is_prefix_byte(i_rx_data)) begin
                            w_emit    = 1'b1;
                            w_evt.brk = 1'b1;
                        end
                    end
                    ST_PFX_E0F0: begin
                        w_stateNext = ST_IDLE;
                        if (!is_prefix_byte(i_rx_data)) begin
                            w_emit    = 1'b1;
                            w_evt.ext = 1'b1;
                            w_evt.brk = 1'b1;
                        end
                    end
                    default: begin
                        w_stateNext = ST_IDLE;
                    end
                endcase
            end
        end else if (w_expire) begin
            w_stateNext = ST_IDLE;
        end
    end

    assign w_pop = w_keyValid && i_key_ready;

    ps2_evt_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (KEY_EVT_W)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_push     (w_emit),
        .i_wdata    (w_evt),
        .i_pop      (w_pop),
        .o_rdata    (w_headEvt),
        .o_valid    (w_keyValid),
        .o_overflow (w_overflow)
    );

    assign o_key_valid = w_keyValid;
    assign o_key_code  = w_headEvt.code;
    assign o_key_ext   = w_headEvt.ext;
    assign o_key_brk   = w_headEvt.brk;

    // Sticky error flags; a new error in the clear cycle keeps its bit set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= 2'b00;
        end else begin
            r_err[0] <= w_overflow || (r_err[0] && !i_clr_err);
            r_err[1] <= w_expire   || (r_err[1] && !i_clr_err);
        end
    end

    assign o_err = r_err;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ps2_scan_ctrl
// Scoreboard bench for ps2_scan_ctrl: expected events are queued as bytes are
// driven and compared in order whenever the DUT hands an event over.
// ----------------------------------------------------------------------------
module tb_ps2_scan_ctrl;

    localparam int T_CYC = 16;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rstN;
    logic       rxDoneTick;
    logic [7:0] rxData;
    logic       rxBusy;
    logic       rxEn;
    logic       rxAbort;
    logic       keyValid;
    logic       keyReady;
    logic [7:0] keyCode;
    logic       keyExt;
    logic       keyBrk;
    logic [1:0] err;
    logic       clrErr;

    int         totalChecks = 0;
    int         badChecks   = 0;
    logic [9:0] sbQ [$];

    ps2_scan_ctrl #(
        .TIMEOUT_CYC (T_CYC),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rstN),
        .i_rx_done_tick (rxDoneTick),
        .i_rx_data      (rxData),
        .i_rx_busy      (rxBusy),
        .o_rx_en        (rxEn),
        .o_rx_abort     (rxAbort),
        .o_key_valid    (keyValid),
        .i_key_ready    (keyReady),
        .o_key_code     (keyCode),
        .o_key_ext      (keyExt),
        .o_key_brk      (keyBrk),
        .o_err          (err),
        .i_clr_err      (clrErr)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got stuck want finish");
        $fatal(1, "[TB] time limit reached");
    end

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalChecks++;
        if (obs !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Drive one received byte (one-cycle tick) together with the consumer ready
    task automatic applyStimulus(input logic [7:0] b, input logic rdy);
        @(negedge clk);
        keyReady   = rdy;
        rxData     = b;
        rxDoneTick = 1'b1;
        @(negedge clk);
        rxDoneTick = 1'b0;
    endtask

    task automatic expectEvt(input logic ext, input logic brk, input logic [7:0] code);
        sbQ.push_back({ext, brk, code});
    endtask

    task automatic clearErr();
        @(negedge clk);
        clrErr = 1'b1;
        @(negedge clk);
        clrErr = 1'b0;
    endtask

    // Hold the receiver busy for exactly one full timeout
    task automatic runWatchdog();
        @(negedge clk);
        rxBusy = 1'b1;
        repeat (T_CYC) @(negedge clk);
        rxBusy = 1'b0;
    endtask

    // Wait (bounded) until every expected event has been handed over
    task automatic waitDrain(input string tag);
        for (int i = 0; i < 30 && sbQ.size() != 0; i++) begin
            @(negedge clk);
            #2;
        end
        checkOutput(tag, sbQ.size(), 0);
    endtask

    // Scoreboard consumer: every accepted head is compared in arrival order
    always begin
        @(negedge clk);
        #1;
        if (rstN && keyValid && keyReady) begin
            if (sbQ.size() == 0) begin
                checkOutput("spurious", 32'(keyValid & keyReady), 32'd0);
            end else begin
                checkOutput("evt", {22'd0, keyExt, keyBrk, keyCode}, {22'd0, sbQ.pop_front()});
            end
        end
    end

    initial begin
        rstN       = 1'b0;
        rxDoneTick = 1'b0;
        rxData     = 8'h00;
        rxBusy     = 1'b0;
        keyReady   = 1'b0;
        clrErr     = 1'b0;

        // Reset values
        @(negedge clk);
        #1;
        checkOutput("rstRxEn",   rxEn,     0);
        checkOutput("rstAbort",  rxAbort,  0);
        checkOutput("rstValid",  keyValid, 0);
        checkOutput("rstCode",   keyCode,  0);
        checkOutput("rstExtBrk", {keyExt, keyBrk}, 0);
        checkOutput("rstErr",    err,      0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("rxEnAfterRst", rxEn, 1);

        // Plain make, latency, then break
        expectEvt(0, 0, 8'h1C);
        applyStimulus(8'h1C, 1'b0);
        #1;
        checkOutput("latValid", keyValid, 1);
        checkOutput("latCode",  keyCode,  8'h1C);
        applyStimulus(8'hF0, 1'b1);
        expectEvt(0, 1, 8'h1C);
        applyStimulus(8'h1C, 1'b1);
        waitDrain("drainBasic");

        // Extended make/break and repeated E0
        applyStimulus(8'hE0, 1'b1);
        expectEvt(1, 0, 8'h75);
        applyStimulus(8'h75, 1'b1);
        applyStimulus(8'hE0, 1'b1);
        applyStimulus(8'hF0, 1'b1);
        expectEvt(1, 1, 8'h75);
        applyStimulus(8'h75, 1'b1);
        applyStimulus(8'hE0, 1'b1);
        applyStimulus(8'hE0, 1'b1);
        expectEvt(1, 0, 8'h74);
        applyStimulus(8'h74, 1'b1);
        waitDrain("drainExt");

        // Overflow: fifth event dropped, head held stable while stalled
        expectEvt(0, 0, 8'h15);
        applyStimulus(8'h15, 1'b0);
        expectEvt(0, 0, 8'h16);
        applyStimulus(8'h16, 1'b0);
        expectEvt(0, 0, 8'h1D);
        applyStimulus(8'h1D, 1'b0);
        expectEvt(0, 0, 8'h1E);
        applyStimulus(8'h1E, 1'b0);
        applyStimulus(8'h24, 1'b0);
        #1;
        checkOutput("ovfErr",  err,      2'b01);
        checkOutput("ovfHead", keyCode,  8'h15);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("holdValid", keyValid, 1);
        checkOutput("holdCode",  keyCode,  8'h15);
        clearErr();
        #1;
        checkOutput("clrErr", err, 2'b00);
        // Push and pop together while full: no overflow
        expectEvt(0, 0, 8'h2C);
        applyStimulus(8'h2C, 1'b1);
        #1;
        checkOutput("fullPushPopErr", err, 2'b00);
        waitDrain("drainOvf");
        checkOutput("postDrainErr", err, 2'b00);

        // Watchdog expiry discards a pending F0
        applyStimulus(8'hF0, 1'b1);
        @(negedge clk);
        rxBusy = 1'b1;
        repeat (T_CYC - 1) @(negedge clk);
        #1;
        checkOutput("wdEarly", rxAbort, 0);
        @(negedge clk);
        #1;
        checkOutput("wdAbort", rxAbort, 1);
        checkOutput("wdRxEn",  rxEn,    0);
        checkOutput("wdErr",   err,     2'b10);
        @(negedge clk);
        rxBusy = 1'b0;
        #1;
        checkOutput("wdPulse", rxAbort, 0);
        checkOutput("wdRxEnBack", rxEn, 1);
        expectEvt(0, 0, 8'h1C);
        applyStimulus(8'h1C, 1'b1);
        waitDrain("drainWd");
        clearErr();

        // Byte arriving in the expiry cycle wins over the abort
        applyStimulus(8'hE0, 1'b1);
        @(negedge clk);
        rxBusy = 1'b1;
        repeat (T_CYC - 1) @(negedge clk);
        expectEvt(1, 0, 8'h74);
        rxData     = 8'h74;
        rxDoneTick = 1'b1;
        @(negedge clk);
        rxDoneTick = 1'b0;
        rxBusy     = 1'b0;
        #1;
        checkOutput("tickAbort", rxAbort, 0);
        checkOutput("tickErr",   err,     2'b00);
        waitDrain("drainTick");

        // Error bytes mid-prefix return to idle without emitting
        applyStimulus(8'hF0, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        expectEvt(0, 0, 8'h1C);
        applyStimulus(8'h1C, 1'b1);
        applyStimulus(8'hE0, 1'b1);
        applyStimulus(8'h00, 1'b1);
        expectEvt(0, 0, 8'h75);
        applyStimulus(8'h75, 1'b1);
        waitDrain("drainErrByte");

        // Reset with events queued, an error flagged and F0 pending
        runWatchdog();
        #1;
        checkOutput("preRstErr", err, 2'b10);
        applyStimulus(8'h1C, 1'b0);
        applyStimulus(8'h32, 1'b0);
        applyStimulus(8'h21, 1'b0);
        applyStimulus(8'hF0, 1'b0);
        #1;
        checkOutput("preRstValid", keyValid, 1);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        checkOutput("midRstValid", keyValid, 0);
        checkOutput("midRstErr",   err,      2'b00);
        checkOutput("midRstRxEn",  rxEn,     0);
        checkOutput("midRstCode",  keyCode,  8'h00);
        @(negedge clk);
        keyReady = 1'b1;
        @(negedge clk);
        rstN = 1'b1;
        expectEvt(0, 0, 8'h1C);
        applyStimulus(8'h1C, 1'b1);
        waitDrain("drainRst");

        repeat (4) @(negedge clk);
        #2;
        checkOutput("finalQueue", sbQ.size(), 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
